coef_rom_loader: RTL
====================

Name: coef_rom_loader

Overview:
- Parametrised successor to the fixed 8x4 coefficient loader.
- Streams a constant coefficient matrix, packed several elements per word, into a downstream coefficient RAM through a valid/ready write port.
- Adds a start/restart control, write backpressure, a done level and a done pulse, and optional auto-start after reset.
- Sits between reset/control logic and the matrix-multiply coefficient memory.

Parameters:
- ELEM_W, 7, bit width of one coefficient element.
- ELEMS_PER_WORD, 2, elements packed per RAM word.
- ROWS, 8, matrix rows.
- COLS, 4, matrix columns.
- ADDR_W, 4, RAM address width; must satisfy 2^ADDR_W >= NUM_WORDS.
- AUTO_START, 1, 1 = first load begins automatically after reset release; 0 = wait for start.
- COEF_INIT, see Behaviour, flat ROWS*COLS*ELEM_W constant. Element (r,c) is at slice index c*ROWS+r, and index 0 sits in the LSBs.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle request to (re)load; honoured in IDLE or DONE, ignored in LOAD.
- w_en  out  1  write valid.
- w_ready  in  1  RAM accepts the write this cycle.
- w_addr  out  ADDR_W  RAM word address.
- w_data  out  ELEM_W*ELEMS_PER_WORD  packed word.
- busy  out  1  high while in LOAD.
- done  out  1  level; high in DONE until the next accepted start.
- done_pulse  out  1  one-cycle pulse on entry to DONE.
- checksum  out  16  running word checksum (see Optional Feature).

Behaviour:
- Derived values: WORD_W = ELEM_W*ELEMS_PER_WORD; NUM_WORDS = ROWS*COLS/ELEMS_PER_WORD.
- Elaboration error if ROWS*COLS is not divisible by ELEMS_PER_WORD, or if NUM_WORDS > 2^ADDR_W.
- Packing order is column-major:
  - Word k holds elements k*ELEMS_PER_WORD .. k*ELEMS_PER_WORD+ELEMS_PER_WORD-1.
  - The lowest-index element goes in the MSBs.
  - With the defaults, word 0 = {e(0,0), e(1,0)}.
- Default COEF_INIT: column 0 rows 0..7 = 1..8; all other elements = 1.
- Reset (rst=1, asynchronous): state IDLE; w_en, w_addr, w_data, busy, done, done_pulse and checksum are all 0; internal word counter is 0.
- FSM with states IDLE, LOAD, DONE:
  - IDLE -> LOAD when start=1 at a rising edge, or at the first edge after reset release when AUTO_START=1.
  - LOAD -> LOAD while words remain.
  - LOAD -> DONE on the edge where the last word (index NUM_WORDS-1) is accepted.
  - DONE -> LOAD when start=1.
- Entering LOAD: counter = 0, w_en = 1, w_addr = 0, w_data = word 0, checksum cleared to 0.
- All outputs are registered; no combinational path from w_ready to any output.
- Transfer rule: a transfer occurs at a rising edge when w_en && w_ready.
  - On a transfer, the counter increments; w_addr and w_data move to the next word on the same edge.
- Backpressure: while w_ready=0, w_en stays high and w_addr/w_data stay stable.
- Latency: with w_ready held at 1 and start sampled at edge N:
  - Transfers happen at edges N+1 .. N+NUM_WORDS.
  - done rises after edge N+NUM_WORDS.
  - done_pulse is high for exactly that one cycle.
- On entering DONE: w_en = 0, w_addr holds the last address, busy = 0.
- start asserted during LOAD has no effect, including on the last-transfer edge.
- start in DONE: done drops and busy rises on the same edge; the sequence restarts from address 0.
- Reset mid-LOAD: immediate return to reset values. If AUTO_START=1, the load restarts from address 0 after release.
- The address counter never wraps; the FSM leaves LOAD before the counter could pass NUM_WORDS-1.

Optional Feature:
- Macro COEF_LOAD_CHECKSUM_EN.
- When defined:
  - checksum accumulates the sum modulo 2^16 of every accepted w_data, zero-extended to 16 bits; words wider than 16 bits are truncated to 16.
  - The accumulator is cleared on entry to LOAD and holds its value in DONE.
- When undefined: checksum is tied to 0 and no accumulator logic exists.

Test Plan:
- Defaults, AUTO_START=1, w_ready=1, release reset -> 16 writes to addresses 0..15. Word 0 = 14'h0082, word 1 = 14'h0184, word 3 = 14'h0388, word 4 = 14'h0081, word 15 = 14'h0081. done rises 16 cycles after the first write; done_pulse is 1 cycle.
- AUTO_START=0, no start for 20 cycles -> w_en = 0, done = 0. Then pulse start -> same 16-write sequence as the first scenario.
- w_ready=0 for 3 cycles while w_addr=5 -> w_en, w_addr=5 and w_data=14'h0081 stable for 3 cycles. Exactly one write to address 5, and the total write count stays 16.
- start pulses at addresses 7 and 15 during LOAD -> ignored, single done_pulse. start in DONE -> done drops and the second pass begins at address 0.
- rst asserted at address 9 -> all outputs 0 asynchronously. After release with AUTO_START=1, writes restart at address 0.
- COEF_LOAD_CHECKSUM_EN defined, defaults -> checksum = 16'h0E20 in DONE. Without the macro, checksum stays 0 throughout.

Source files
------------

// File: rtl/coef_rom_loader.sv
// ---------------------------------------------------------------------------
// coef_rom_loader
//   Streams a constant coefficient matrix (COEF_INIT) into a downstream
//   coefficient RAM, several elements packed per word. The write port uses
//   valid/ready handshaking. Words are taken in column-major order, and the
//   lowest-index element of each word goes in the MSBs.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active high
//   start      in   one-cycle (re)load request, honoured in IDLE or DONE
//   w_en       out  write valid
//   w_ready    in   RAM accepts the write this cycle
//   w_addr     out  RAM word address
//   w_data     out  packed coefficient word
//   busy       out  high while loading
//   done       out  high after a complete load, until the next accepted start
//   done_pulse out  one-cycle pulse on entry to DONE
//   checksum   out  running 16-bit sum of accepted words (optional feature)
//
// Optional feature macro: COEF_LOAD_CHECKSUM_EN
//   When defined, checksum accumulates the accepted words modulo 2^16.
//   When undefined, checksum is tied to zero.
// ---------------------------------------------------------------------------
module coef_rom_loader #(
    parameter int ELEM_W         = 7,
    parameter int ELEMS_PER_WORD = 2,
    parameter int ROWS           = 8,
    parameter int COLS           = 4,
    parameter int ADDR_W         = 4,
    parameter int AUTO_START     = 1,
    // Column 0 holds rows 0..7 = 1..8. Every other element is 1.
    // Slice index 0 is in the LSBs.
    parameter logic [ROWS*COLS*ELEM_W-1:0] COEF_INIT = {
        {24{7'd1}},
        7'd8, 7'd7, 7'd6, 7'd5, 7'd4, 7'd3, 7'd2, 7'd1
    }
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic                             w_en,
    input  logic                             w_ready,
    output logic [ADDR_W-1:0]                w_addr,
    output logic [ELEM_W*ELEMS_PER_WORD-1:0] w_data,
    output logic                             busy,
    output logic                             done,
    output logic                             done_pulse,
    output logic [15:0]                      checksum
);

    localparam int WORD_W    = ELEM_W * ELEMS_PER_WORD;
    localparam int NUM_WORDS = (ROWS * COLS) / ELEMS_PER_WORD;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Reject parameter sets that cannot be packed or addressed.
    generate
        if ((ROWS * COLS) % ELEMS_PER_WORD != 0) begin : g_bad_packing
            $error("coef_rom_loader: ROWS*COLS not divisible by ELEMS_PER_WORD");
        end
        if (NUM_WORDS > (1 << ADDR_W)) begin : g_bad_addr_w
            $error("coef_rom_loader: ADDR_W too small for NUM_WORDS");
        end
    endgenerate

    // Build word k. Element k*EPW+j goes at field (EPW-1-j),
    // so the lowest-index element ends up in the MSBs.
    function automatic logic [WORD_W-1:0] word_at(input logic [ADDR_W-1:0] k);
        logic [WORD_W-1:0] w;
        int                idx;
        w = '0;
        for (int j = 0; j < ELEMS_PER_WORD; j++) begin
            idx = int'(k) * ELEMS_PER_WORD + j;
            w[(ELEMS_PER_WORD-1-j)*ELEM_W +: ELEM_W] = COEF_INIT[idx*ELEM_W +: ELEM_W];
        end
        return w;
    endfunction

    logic [1:0]        state;
    logic              auto_armed;
    logic              load_start_s;
    logic              xfer_s;
    logic [ADDR_W-1:0] next_addr_s;
    logic [WORD_W-1:0] next_word_s;

    // Decode the load-start and transfer events, and look ahead to the next word.
    always_comb begin
        load_start_s = 1'b0;
        xfer_s       = 1'b0;
        next_addr_s  = w_addr + ONE_ADDR;
        next_word_s  = word_at(next_addr_s);
        case (state)
            ST_IDLE: load_start_s = start | auto_armed;
            ST_DONE: load_start_s = start;
            ST_LOAD: xfer_s       = w_en & w_ready;
            default: load_start_s = 1'b0;
        endcase
    end

    // FSM and registered write-port outputs. The last word is addressed as
    // LAST_ADDR, so the address register never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            auto_armed <= (AUTO_START != 0);
            w_en       <= 1'b0;
            w_addr     <= '0;
            w_data     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            // Auto-start applies only to the first edge after reset release.
            auto_armed <= 1'b0;
            done_pulse <= 1'b0;
            if (load_start_s) begin
                state  <= ST_LOAD;
                w_en   <= 1'b1;
                w_addr <= '0;
                w_data <= word_at('0);
                busy   <= 1'b1;
                done   <= 1'b0;
            end else if (xfer_s) begin
                if (w_addr == LAST_ADDR) begin
                    state      <= ST_DONE;
                    w_en       <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    done_pulse <= 1'b1;
                end else begin
                    w_addr <= next_addr_s;
                    w_data <= next_word_s;
                end
            end else if (state > ST_DONE) begin
                state <= ST_IDLE;
                w_en  <= 1'b0;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else begin
                state <= state;
            end
        end
    end

`ifdef COEF_LOAD_CHECKSUM_EN
    // Zero-extend or truncate a word to 16 bits.
    function automatic logic [15:0] to16(input logic [WORD_W-1:0] w);
        logic [WORD_W+15:0] ext;
        ext = {16'd0, w};
        return ext[15:0];
    endfunction

    // Sum accepted words. The sum is cleared on entry to LOAD and held in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= 16'd0;
        end else if (load_start_s) begin
            checksum <= 16'd0;
        end else if (xfer_s) begin
            checksum <= checksum + to16(w_data);
        end else begin
            checksum <= checksum;
        end
    end
`else
    assign checksum = 16'd0;
`endif

endmodule
